// File: rtl/dot_rr_scheduler.sv
// Round-robin scheduler sharing one 16-lane serial dot-product engine among NUM_REQ requesters.
// Optional job/stall performance counters are built when DOT_RR_SCHED_PERF_EN is defined.
module dot_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_a,
  input  logic [NUM_REQ*128-1:0] req_b,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_data,
  output logic                   eng_start,
  output logic [127:0]           eng_a,
  output logic [127:0]           eng_b,
  input  logic [31:0]            eng_c,
  input  logic                   eng_done,
`ifdef DOT_RR_SCHED_PERF_EN
  output logic [31:0]            perf_jobs,
  output logic [31:0]            perf_stall,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  int               cand;

  // Scan downward so the candidate closest after last_grant is the final one written.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    cand       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[IDX_W'(cand)]) begin
        pick       = IDX_W'(cand);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick_valid) begin
      req_ready[pick] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      resp_valid <= '0;
      resp_data  <= '0;
      eng_start  <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            eng_a     <= req_a[int'(pick)*128 +: 128];
            eng_b     <= req_b[int'(pick)*128 +: 128];
            grant     <= pick;
            eng_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            resp_data         <= eng_c;
            resp_valid[grant] <= 1'b1;
            state             <= RESP;
          end
        end
        RESP: begin
          // Only the owner's ready can complete the response.
          if (resp_ready[grant]) begin
            resp_valid <= '0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DOT_RR_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (state == RESP && resp_ready[grant]) begin
        perf_jobs <= perf_jobs + 32'd1;
      end
      if (|req_valid && req_ready == '0) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
